// File: rtl/ex_div_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_div_if
// Description : Request/response bundle between the EX stage and ex_div.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// Module      : ex_div
// Description : 32-step restoring divider for DIV/DIVU; result {rem, quo}.
//               Optional macro DIV_EARLY_OUT_EN: 1-cycle result if |a| < |b|.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_div (
    input  wire logic clk,
    input  wire logic rst,
    ex_div_if.slave   bus
);
    localparam logic [1:0] c_IDLE   = 2'b00;
    localparam logic [1:0] c_BYZERO = 2'b01;
    localparam logic [1:0] c_ON     = 2'b10;
    localparam logic [1:0] c_END    = 2'b11;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_work;
    logic [31:0] r_divisor;
    logic        r_neg_quo;
    logic        r_neg_rem;
    logic [63:0] r_result;
    logic        r_ready;

    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [64:0] w_shift;
    logic [33:0] w_trial;
    logic [64:0] w_step;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_early;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign w_mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
    assign w_mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;

    assign w_shift = r_work << 1;
    assign w_trial = {1'b0, w_shift[64:32]} - {2'b00, r_divisor};
    assign w_step  = w_trial[33] ? w_shift : {w_trial[32:0], w_shift[31:1], 1'b1};
    assign w_quo   = r_neg_quo ? (32'd0 - w_step[31:0])  : w_step[31:0];
    assign w_rem   = r_neg_rem ? (32'd0 - w_step[63:32]) : w_step[63:32];

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_mag1 < w_mag2);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= 32'd0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= 64'd0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_result <= 64'd0;
                    r_ready  <= 1'b0;
                    if (bus.start_i && !bus.annul_i) begin
                        r_divisor <= w_mag2;
                        r_neg_quo <= bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                        r_neg_rem <= bus.signed_div_i && bus.opdata1_i[31];
                        if (bus.opdata2_i == 32'd0) begin
                            r_state <= c_BYZERO;
                        end else if (w_early) begin
                            r_result <= {bus.opdata1_i, 32'd0};
                            r_ready  <= 1'b1;
                            r_state  <= c_END;
                        end else begin
                            r_cnt   <= 6'd0;
                            r_work  <= {33'd0, w_mag1};
                            r_state <= c_ON;
                        end
                    end
                end
                c_BYZERO: begin
                    r_result <= 64'd0;
                    r_ready  <= 1'b1;
                    r_state  <= c_END;
                end
                c_ON: begin
                    if (bus.annul_i) begin
                        r_cnt    <= 6'd0;
                        r_work   <= 65'd0;
                        r_result <= 64'd0;
                        r_ready  <= 1'b0;
                        r_state  <= c_IDLE;
                    end else begin
                        r_work <= w_step;
                        r_cnt  <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_result <= {w_rem, w_quo};
                            r_ready  <= 1'b1;
                            r_state  <= c_END;
                        end
                    end
                end
                default: begin
                    // END: hold the result until EX drops its request
                    if (!bus.start_i) begin
                        r_result <= 64'd0;
                        r_ready  <= 1'b0;
                        r_cnt    <= 6'd0;
                        r_state  <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
endmodule
`default_nettype wire
